// File: rtl/dircc_fanout_sender_if.sv
// dircc_fanout_sender_if: config, request and per-target beat signals of the fanout sender.
interface dircc_fanout_sender_if #(
  parameter int TABLE_DEPTH = 16,
  parameter int PAYLOAD_W = 32
);
  localparam int IDX_W = $clog2(TABLE_DEPTH);
  localparam int CNT_W = $clog2(TABLE_DEPTH + 1);
  logic cfg_write;
  logic [IDX_W-1:0] cfg_address;
  logic [47:0] cfg_writedata;
  logic req_valid;
  logic req_ready;
  logic [IDX_W-1:0] req_base;
  logic [CNT_W-1:0] req_count;
  logic [PAYLOAD_W-1:0] req_payload;
  logic out_valid;
  logic out_ready;
  logic [15:0] out_hw_addr;
  logic [15:0] out_sw_addr;
  logic [7:0] out_port;
  logic [7:0] out_flag;
  logic [PAYLOAD_W-1:0] out_payload;
  logic out_last;
  logic busy;
  modport master (
    output cfg_write, cfg_address, cfg_writedata, req_valid, req_base, req_count, req_payload, out_ready,
    input req_ready, out_valid, out_hw_addr, out_sw_addr, out_port, out_flag, out_payload, out_last, busy
  );
  modport slave (
    input cfg_write, cfg_address, cfg_writedata, req_valid, req_base, req_count, req_payload, out_ready,
    output req_ready, out_valid, out_hw_addr, out_sw_addr, out_port, out_flag, out_payload, out_last, busy
  );
endinterface

// File: rtl/dircc_fanout_sender.sv
// dircc_fanout_sender: sends one payload to a run of table targets, one beat per cycle.
// Defining DIRCC_FANOUT_STATS_EN adds stat_msgs/stat_beats counters.
module dircc_fanout_sender #(
  parameter int TABLE_DEPTH = 16,
  parameter int PAYLOAD_W = 32
) (
  input logic clk,
  input logic reset_n,
  dircc_fanout_sender_if.slave bus
`ifdef DIRCC_FANOUT_STATS_EN
  ,
  output logic [31:0] stat_msgs,
  output logic [31:0] stat_beats
`endif
);
  localparam int IDX_W = $clog2(TABLE_DEPTH);
  localparam int CNT_W = $clog2(TABLE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TABLE_DEPTH);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q;
  logic [47:0] tbl_q [TABLE_DEPTH];
  logic [47:0] entry_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] req_cnt;
  logic ready_q, valid_q, last_q, busy_q;
  logic accept, fire;
  logic [47:0] rd_entry;
  assign req_cnt = bus.req_count > DEPTH_C ? DEPTH_C : bus.req_count;
  assign accept = state_q == IDLE && ready_q && bus.req_valid;
  assign fire = valid_q && bus.out_ready;
  assign rd_entry = tbl_q[state_q == IDLE ? bus.req_base : idx_q];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < TABLE_DEPTH; i++) tbl_q[i] <= '0;
    else if (bus.cfg_write)
      tbl_q[bus.cfg_address] <= bus.cfg_writedata;
  // Beat fields are snapshotted into entry_q so later table writes never disturb a presented beat
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      entry_q <= '0;
      payload_q <= '0;
      idx_q <= '0;
      rem_q <= '0;
    end else if (state_q == IDLE) begin
      ready_q <= 1'b1;
      if (accept && req_cnt != '0) begin
        state_q <= EMIT;
        ready_q <= 1'b0;
        valid_q <= 1'b1;
        busy_q <= 1'b1;
        entry_q <= rd_entry;
        payload_q <= bus.req_payload;
        last_q <= req_cnt == CNT_W'(1);
        idx_q <= bus.req_base + 1'b1;
        rem_q <= req_cnt - 1'b1;
      end
    end else if (fire) begin
      if (last_q) begin
        state_q <= IDLE;
        ready_q <= 1'b1;
        valid_q <= 1'b0;
        busy_q <= 1'b0;
        last_q <= 1'b0;
      end else begin
        entry_q <= rd_entry;
        last_q <= rem_q == CNT_W'(1);
        idx_q <= idx_q + 1'b1;
        rem_q <= rem_q - 1'b1;
      end
    end
  assign bus.req_ready = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_hw_addr = entry_q[47:32];
  assign bus.out_sw_addr = entry_q[31:16];
  assign bus.out_port = entry_q[15:8];
  assign bus.out_flag = entry_q[7:0];
  assign bus.out_payload = payload_q;
  assign bus.out_last = last_q;
  assign bus.busy = busy_q;
`ifdef DIRCC_FANOUT_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stat_msgs <= '0;
      stat_beats <= '0;
    end else begin
      if (accept) stat_msgs <= stat_msgs + 1'b1;
      if (fire) stat_beats <= stat_beats + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dircc_fanout_sender.sv
// tb_dircc_fanout_sender: directed and random fanout traffic checked against a queue-based beat model.
module tb_dircc_fanout_sender;
  localparam int TD = 16;
  localparam int PW = 32;
  localparam int IW = $clog2(TD);
  localparam int CW = $clog2(TD + 1);
  typedef struct packed {
    logic [47:0] e;
    logic [PW-1:0] p;
    logic l;
  } beat_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0;
  int errors = 0;
  beat_t q[$];
  logic [47:0] mt [TD];
  bit m_up = 1'b0;
  bit f, a;
  int n;
  int unsigned m_msgs = 0;
  int unsigned m_beats = 0;
  dircc_fanout_sender_if #(.TABLE_DEPTH(TD), .PAYLOAD_W(PW)) bus();
`ifdef DIRCC_FANOUT_STATS_EN
  logic [31:0] stat_msgs, stat_beats;
`endif
  dircc_fanout_sender #(.TABLE_DEPTH(TD), .PAYLOAD_W(PW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef DIRCC_FANOUT_STATS_EN
    ,
    .stat_msgs(stat_msgs),
    .stat_beats(stat_beats)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [47:0] ent(input int e);
    return {16'(256 + e), 16'(e * 3), 8'(e), 8'hC3};
  endfunction
  task automatic wr(input int adr, input logic [47:0] d);
    bus.cfg_write = 1'b1;
    bus.cfg_address = IW'(adr);
    bus.cfg_writedata = d;
    @(negedge clk);
    bus.cfg_write = 1'b0;
  endtask
  task automatic req(input int b, input int c, input logic [PW-1:0] p);
    bus.req_valid = 1'b1;
    bus.req_base = IW'(b);
    bus.req_count = CW'(c);
    bus.req_payload = p;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (bus.req_ready && !bus.out_valid) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: block still busy after 200 cycles at %0t", $time);
  endtask
  // Model: a request expands into its whole list of beats; each accepted beat pops one
  initial begin
    foreach (mt[i]) mt[i] = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        q.delete();
        foreach (mt[i]) mt[i] = '0;
        m_up = 1'b0;
        m_msgs = 0;
        m_beats = 0;
      end else begin
        f = bus.out_ready && q.size() != 0;
        a = bus.req_valid && m_up && q.size() == 0;
        if (f) begin
          void'(q.pop_front());
          m_beats++;
        end
        if (a) begin
          n = int'(bus.req_count) > TD ? TD : int'(bus.req_count);
          for (int k = 0; k < n; k++)
            q.push_back('{e: mt[(int'(bus.req_base) + k) % TD], p: bus.req_payload, l: k == n - 1});
          m_msgs++;
        end
        if (bus.cfg_write) mt[bus.cfg_address] = bus.cfg_writedata;
        m_up = 1'b1;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      chk("reset_outputs", {bus.out_valid, bus.req_ready, bus.busy, bus.out_last,
          bus.out_hw_addr, bus.out_sw_addr, bus.out_port, bus.out_flag}, '0);
      chk("reset_payload", bus.out_payload, '0);
    end else begin
      chk("req_ready", bus.req_ready, m_up && q.size() == 0);
      chk("out_valid", bus.out_valid, q.size() != 0);
      chk("busy", bus.busy, q.size() != 0);
      if (q.size() != 0) begin
        chk("beat_entry", {bus.out_hw_addr, bus.out_sw_addr, bus.out_port, bus.out_flag}, q[0].e);
        chk("beat_payload", bus.out_payload, q[0].p);
        chk("beat_last", bus.out_last, q[0].l);
      end
`ifdef DIRCC_FANOUT_STATS_EN
      chk("stat_msgs", stat_msgs, m_msgs);
      chk("stat_beats", stat_beats, m_beats);
`endif
    end
  end
  initial begin
    logic [15:0] wrap_hw [4];
    logic [15:0] hold_hw [3];
    int wrap_idx [4];
    int nb;
    wrap_hw = '{16'h10E, 16'h10F, 16'h100, 16'h101};
    hold_hw = '{16'h10E, 16'h10F, 16'h100};
    wrap_idx = '{14, 15, 0, 1};
    bus.cfg_write = 1'b0;
    bus.cfg_address = '0;
    bus.cfg_writedata = '0;
    bus.req_valid = 1'b0;
    bus.req_base = '0;
    bus.req_count = '0;
    bus.req_payload = '0;
    bus.out_ready = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.req_ready, 1'b0);
    chk("reset_valid", bus.out_valid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus.req_ready, 1'b1);
    wr(0, 48'h0001_0000_0000);
    req(0, 1, 32'hA5);
    chk("single_valid", bus.out_valid, 1'b1);
    chk("single_fields", {bus.out_hw_addr, bus.out_sw_addr, bus.out_port, bus.out_flag}, 48'h0001_0000_0000);
    chk("single_payload", bus.out_payload, 32'hA5);
    chk("single_last", bus.out_last, 1'b1);
    @(negedge clk);
    chk("single_done", {bus.out_valid, bus.req_ready}, 2'b01);
    foreach (wrap_idx[i]) wr(wrap_idx[i], ent(wrap_idx[i]));
    req(14, 4, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_hw", bus.out_hw_addr, wrap_hw[k]);
      chk("wrap_last", bus.out_last, k == 3);
      @(negedge clk);
    end
    req(14, 3, 32'hCAFE_0001);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_entry", {bus.out_hw_addr, bus.out_sw_addr, bus.out_port, bus.out_flag}, ent(14));
      bus.cfg_write = k == 1;
      bus.cfg_address = IW'(14);
      bus.cfg_writedata = 48'hFFFF_FFFF_FFFF;
      @(negedge clk);
    end
    bus.cfg_write = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("hold_seq_hw", bus.out_hw_addr, hold_hw[k]);
      chk("hold_seq_last", bus.out_last, k == 2);
      @(negedge clk);
    end
    wait_idle();
    req(3, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("count0_state", {bus.req_ready, bus.out_valid, bus.busy}, 3'b100);
      @(negedge clk);
    end
    req(0, 3, 32'h3333);
    @(negedge clk);
    chk("abort_beat2_hw", bus.out_hw_addr, 16'h101);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_valid", bus.out_valid, 1'b0);
    chk("abort_busy", bus.busy, 1'b0);
    @(negedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", bus.req_ready, 1'b1);
`ifdef DIRCC_FANOUT_STATS_EN
    req(0, 2, 32'h1);
    wait_idle();
    req(0, 0, 32'h2);
    req(0, 5, 32'h3);
    wait_idle();
    chk("stat_msgs_lit", stat_msgs, 32'd3);
    chk("stat_beats_lit", stat_beats, 32'd7);
`endif
    req(0, 16, 32'h0);
    for (int k = 0; k < 16; k++) begin
      chk("readback_valid", bus.out_valid, 1'b1);
      chk("readback_zero", {bus.out_hw_addr, bus.out_sw_addr, bus.out_port, bus.out_flag}, 48'h0);
      @(negedge clk);
    end
    wait_idle();
    req(2, 20, 32'h5A5A);
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) nb++;
      @(negedge clk);
    end
    chk("saturated_beats", nb, 16);
    for (int c = 0; c < 3000; c++) begin
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.req_valid = $urandom_range(0, 2) == 0;
      bus.req_base = IW'($urandom);
      bus.req_count = CW'($urandom_range(0, TD + 3));
      bus.req_payload = $urandom;
      bus.cfg_write = !bus.req_valid && q.size() == 0 && $urandom_range(0, 1) == 1;
      bus.cfg_address = IW'($urandom);
      bus.cfg_writedata = {16'($urandom), 32'($urandom)};
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.cfg_write = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dircc_fanout_sender.md
DIRCC_FANOUT_SENDER -- requirements
Module: dircc_fanout_sender

Interface
REQ-001 Parameter TABLE_DEPTH, 16, number of fanout target entries (power of 2, 2..256).
REQ-002 Parameter PAYLOAD_W, 32, message payload width in bits.
REQ-003 Derived widths: IDX_W = clog2(TABLE_DEPTH); CNT_W = clog2(TABLE_DEPTH+1).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 cfg_write  in  1  table write strobe.
REQ-008 cfg_address  in  IDX_W  table entry written.
REQ-009 cfg_writedata  in  48  entry {hw_addr[47:32], sw_addr[31:16], port[15:8], flag[7:0]}.
REQ-010 req_valid / req_ready  in / out  1  send-request handshake.
REQ-011 req_base  in  IDX_W  first target entry for this message.
REQ-012 req_count  in  CNT_W  number of targets.
REQ-013 req_payload  in  PAYLOAD_W  message body.
REQ-014 out_valid / out_ready  out / in  1  per-target beat handshake.
REQ-015 out_hw_addr 16, out_sw_addr 16, out_port 8, out_flag 8, out_payload PAYLOAD_W, out_last 1  all out; current beat fields.
REQ-016 busy  out  1  high while a fanout is in progress.

Function
REQ-017 The block SHALL have two states: IDLE and EMIT.
REQ-018 IDLE: req_ready=1; on req_valid&&req_ready with req_count>0, latch payload, index=req_base, remaining=req_count, and go to EMIT.
REQ-019 A request with req_count=0 SHALL be accepted in one cycle, emit no beat, and leave the block in IDLE.
REQ-020 req_count>TABLE_DEPTH SHALL saturate to TABLE_DEPTH.
REQ-021 EMIT: req_ready=0, busy=1, and out_valid=1 from the cycle after acceptance, giving a latency of 1 cycle.
REQ-022 Beat fields SHALL be the table entry at index plus the latched payload; out_last=1 when remaining=1.
REQ-023 Outputs SHALL stay stable while out_valid && !out_ready.
REQ-024 On out_valid&&out_ready: index = (index+1) mod TABLE_DEPTH (wraps), remaining decrements, and the next beat is presented the following cycle, giving one beat per cycle at full throughput.
REQ-025 When the out_last beat is accepted, the block SHALL return to IDLE and accept the next request no earlier than the following cycle.
REQ-026 Table reads SHALL be combinational from registers.
REQ-027 A cfg write SHALL take effect from the next cycle.
REQ-028 A write to the entry currently presented SHALL NOT alter a beat already being presented; each beat's fields are captured when it is loaded.

Reset
REQ-029 While reset_n=0: state=IDLE; out_valid, out_last and busy=0; all out_* data=0; req_ready=0; all table entries=0.
REQ-030 req_ready SHALL rise on the first clock after reset_n deasserts.
REQ-031 Reset asserted mid-EMIT SHALL abort the fanout immediately; no further beats of that message are emitted.

Configuration
REQ-032 Macro DIRCC_FANOUT_STATS_EN defined: add outputs stat_msgs (32) and stat_beats (32), counting accepted requests and accepted beats, wrapping at 2^32 and reset to 0.
REQ-033 Macro DIRCC_FANOUT_STATS_EN undefined: those ports and counters SHALL be absent, with no other behavioural difference.

Verification
REQ-034 Write entry0={1,0,0,0}; request base0/count1/payload 0xA5 -> one beat next cycle with hw_addr=1, sw_addr=0, port=0, flag=0, payload 0xA5, out_last=1.
REQ-035 Request base14/count4 with TABLE_DEPTH=16 -> beats from entries 14, 15, 0, 1 in order; out_last only on the 4th beat.
REQ-036 Hold out_ready=0 for 5 cycles mid-fanout -> fields unchanged throughout; no beat lost or duplicated.
REQ-037 Request count0 -> req_ready stays 1, out_valid never asserts, and busy stays 0.
REQ-038 Assert reset_n=0 during the 2nd of 3 beats -> out_valid=0 immediately; after release, req_ready=1 and the table reads back as zero.
REQ-039 With DIRCC_FANOUT_STATS_EN: 3 requests of counts 2, 0 and 5 -> stat_msgs=3, stat_beats=7.
